// File: rtl/conv_seq_ctrl_if.sv
// rtl/conv_seq_ctrl_if.sv - start/abort handshake plus SRAM, L0, MAC-array and drain strobes of conv_seq_ctrl
interface conv_seq_ctrl_if #(
   parameter int ADDR_W  = 7,
   parameter int OADDR_W = 4,
   parameter int KIJ_W   = 4
);
   logic               start;
   logic               abort;
   logic               l0_full;
   logic               busy;
   logic               op_done;
   logic [ADDR_W-1:0]  i_addr;
   logic               i_cen;
   logic               i_wen;
   logic               l0_wr;
   logic               l0_rd;
   logic [1:0]         inst;
   logic [KIJ_W-1:0]   kij;
   logic [OADDR_W-1:0] o_addr;
   logic               o_cen;
   logic               o_wen;

   modport master (
      input  start, abort, l0_full,
      output busy, op_done, i_addr, i_cen, i_wen, l0_wr, l0_rd, inst, kij, o_addr, o_cen, o_wen
   );

   modport slave (
      output start, abort, l0_full,
      input  busy, op_done, i_addr, i_cen, i_wen, l0_wr, l0_rd, inst, kij, o_addr, o_cen, o_wen
   );
endinterface

// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - weight-stationary corelet control sequencer; CONV_SEQ_PERF_EN adds perf counters
// Walks every kij through weight load/push and activation load/push/flush, then drains the output SRAM.
module conv_seq_ctrl #(
   parameter int ROW     = 8,
   parameter int KSIZE   = 3,
   parameter int IN_W    = 6,
   parameter int W_BASE  = 0,
   parameter int A_BASE  = 72,
   parameter int WSETTLE = 16,
   parameter int FLUSH   = 20,
   parameter int ADDR_W  = 7,
   parameter int OADDR_W = 4
) (
   input  logic            clk,
   input  logic            reset,
   conv_seq_ctrl_if.master bus
`ifdef CONV_SEQ_PERF_EN
   ,
   output logic [31:0]     perf_cycles,
   output logic [15:0]     perf_stalls
`endif
);
   localparam int KK    = KSIZE * KSIZE;
   localparam int OUT_W = IN_W - KSIZE + 1;
   localparam int N_OUT = OUT_W * OUT_W;
   localparam int KIJ_W = (KK > 1) ? $clog2(KK) : 1;
   localparam int M1    = (ROW + WSETTLE > N_OUT + 1) ? ROW + WSETTLE : N_OUT + 1;
   localparam int M2    = (M1 > FLUSH) ? M1 : FLUSH;
   localparam int M3    = (M2 > ROW + 1) ? M2 : ROW + 1;
   localparam int CNT_W = $clog2(M3 + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_W_LOAD, S_W_PUSH, S_A_LOAD, S_A_PUSH, S_A_FLUSH, S_DRAIN, S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                w_end;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    r_col;
   logic [KIJ_W-1:0]    r_kij;
   logic [KIJ_W-1:0]    r_kj;
   logic [ADDR_W-1:0]   r_wbase;
   logic [ADDR_W-1:0]   r_kbase;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_rd_pend;
   logic                w_load;
   logic                w_rd_phase;
   logic                w_rd;
   logic                w_last_kij;

   logic                w_busy;
   logic                w_op_done;
   logic                w_l0_rd;
   logic [1:0]          w_inst;
   logic [OADDR_W-1:0]  w_o_addr;
   logic                w_o_en;

   assign w_load     = (r_state == S_W_LOAD) || (r_state == S_A_LOAD);
   assign w_rd_phase = ((r_state == S_W_LOAD) && (r_cnt < CNT_W'(ROW))) ||
                       ((r_state == S_A_LOAD) && (r_cnt < CNT_W'(N_OUT)));
   assign w_rd       = w_rd_phase && !bus.l0_full;
   assign w_last_kij = (r_kij == KIJ_W'(KK - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_end  = 1'b0;
      w_next = r_state;
      case (r_state)
         S_W_LOAD:  w_end = (r_cnt == CNT_W'(ROW));
         S_W_PUSH:  w_end = (r_cnt == CNT_W'(ROW + WSETTLE - 1));
         S_A_LOAD:  w_end = (r_cnt == CNT_W'(N_OUT));
         S_A_PUSH:  w_end = (r_cnt == CNT_W'(N_OUT - 1));
         S_A_FLUSH: w_end = (r_cnt == CNT_W'(FLUSH - 1));
         S_DRAIN:   w_end = (r_cnt == CNT_W'(N_OUT - 1));
         S_DONE:    w_end = 1'b1;
         default:   w_end = 1'b0;
      endcase
      if (bus.abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    if (bus.start) w_next = S_W_LOAD;
            S_W_LOAD:  if (w_end) w_next = S_W_PUSH;
            S_W_PUSH:  if (w_end) w_next = S_A_LOAD;
            S_A_LOAD:  if (w_end) w_next = S_A_PUSH;
            S_A_PUSH:  if (w_end) w_next = S_A_FLUSH;
            S_A_FLUSH: if (w_end) w_next = w_last_kij ? S_DRAIN : S_W_LOAD;
            S_DRAIN:   if (w_end) w_next = S_DONE;
            default:   w_next = S_IDLE;
         endcase
      end
   end

   // Activation addresses step by 1 along a row and by KSIZE at each row wrap,
   // so only adders are needed; r_kbase tracks ki*IN_W+kj the same way.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt     <= '0;
         r_col     <= '0;
         r_kij     <= '0;
         r_kj      <= '0;
         r_rd_pend <= 1'b0;
         r_wbase   <= ADDR_W'(W_BASE);
         r_kbase   <= ADDR_W'(A_BASE);
         r_addr    <= ADDR_W'(W_BASE);
      end else if (bus.abort) begin
         r_cnt     <= '0;
         r_col     <= '0;
         r_kij     <= '0;
         r_kj      <= '0;
         r_rd_pend <= 1'b0;
         r_wbase   <= ADDR_W'(W_BASE);
         r_kbase   <= ADDR_W'(A_BASE);
         r_addr    <= ADDR_W'(W_BASE);
      end else begin
         r_rd_pend <= w_rd;
         if ((w_next != r_state) || (r_state == S_IDLE)) r_cnt <= '0;
         else if (!w_load || w_rd)                      r_cnt <= r_cnt + 1'b1;

         if ((r_state == S_IDLE) && bus.start) begin
            r_kij   <= '0;
            r_kj    <= '0;
            r_col   <= '0;
            r_wbase <= ADDR_W'(W_BASE);
            r_kbase <= ADDR_W'(A_BASE);
            r_addr  <= ADDR_W'(W_BASE);
         end else if (w_rd) begin
            if ((r_state == S_A_LOAD) && (r_col == CNT_W'(OUT_W - 1))) begin
               r_col  <= '0;
               r_addr <= r_addr + ADDR_W'(KSIZE);
            end else begin
               if (r_state == S_A_LOAD) r_col <= r_col + 1'b1;
               r_addr <= r_addr + 1'b1;
            end
         end else if ((r_state == S_W_PUSH) && w_end) begin
            r_col  <= '0;
            r_addr <= r_kbase;
         end else if ((r_state == S_A_FLUSH) && w_end && !w_last_kij) begin
            r_kij   <= r_kij + 1'b1;
            r_wbase <= r_wbase + ADDR_W'(ROW);
            r_addr  <= r_wbase + ADDR_W'(ROW);
            if (r_kj == KIJ_W'(KSIZE - 1)) begin
               r_kj    <= '0;
               r_kbase <= r_kbase + ADDR_W'(IN_W - KSIZE + 1);
            end else begin
               r_kj    <= r_kj + 1'b1;
               r_kbase <= r_kbase + 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_busy    = (r_state != S_IDLE);
      w_op_done = (r_state == S_DONE);
      w_l0_rd   = 1'b0;
      w_inst    = 2'b00;
      w_o_addr  = '0;
      w_o_en    = 1'b0;
      if ((r_state == S_W_PUSH) && (r_cnt < CNT_W'(ROW))) begin
         w_l0_rd = 1'b1;
         w_inst  = 2'b01;
      end
      if (r_state == S_A_PUSH) begin
         w_l0_rd = 1'b1;
         w_inst  = 2'b10;
      end
      if (r_state == S_DRAIN) begin
         w_o_en   = 1'b1;
         w_o_addr = OADDR_W'(r_cnt);
      end
   end

   assign bus.busy    = w_busy;
   assign bus.op_done = w_op_done;
   assign bus.i_addr  = r_addr;
   assign bus.i_cen   = !w_rd;
   assign bus.i_wen   = 1'b1;
   assign bus.l0_wr   = r_rd_pend;
   assign bus.l0_rd   = w_l0_rd;
   assign bus.inst    = w_inst;
   assign bus.kij     = r_kij;
   assign bus.o_addr  = w_o_addr;
   assign bus.o_cen   = !w_o_en;
   assign bus.o_wen   = !w_o_en;

`ifdef CONV_SEQ_PERF_EN
   logic [31:0] r_perf_cycles;
   logic [15:0] r_perf_stalls;
   logic        w_stall;

   assign w_stall = w_rd_phase && bus.l0_full;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_perf_cycles <= '0;
         r_perf_stalls <= '0;
      end else if ((r_state == S_IDLE) && bus.start && !bus.abort) begin
         r_perf_cycles <= '0;
         r_perf_stalls <= '0;
      end else begin
         if (w_busy)  r_perf_cycles <= r_perf_cycles + 1'b1;
         if (w_stall) r_perf_stalls <= r_perf_stalls + 1'b1;
      end
   end

   assign perf_cycles = r_perf_cycles;
   assign perf_stalls = r_perf_stalls;
`endif
endmodule
